// File: rtl/pll_led.sv
// pll_led
// Simulated PLL lock indicator plus six divided-rate LED blinkers.
// After reset release a lock counter runs for LOCK_CYCLES clock edges and then
// raises the locked flag. Once locked, each channel i toggles its LED every
// DIVi clock edges, giving a 50% duty square wave of period 2*DIVi cycles.
//
// Ports:
//   clk  - system clock (nominal 100 MHz)
//   RST  - synchronous active-high reset
//   led  - led[5:0] divided-rate toggle outputs, led[6] lock indicator
module pll_led #(
  parameter int unsigned LOCK_CYCLES = 64,
  parameter int unsigned DIV0 = 10,
  parameter int unsigned DIV1 = 20,
  parameter int unsigned DIV2 = 40,
  parameter int unsigned DIV3 = 80,
  parameter int unsigned DIV4 = 160,
  parameter int unsigned DIV5 = 320
) (
  input  logic       clk,
  input  logic       RST,
  output logic [6:0] led
);

  localparam int NUM_CH = 6;

  // Terminal counts are precomputed so the per-edge compares are plain
  // equality checks against constants of matching width.
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);

  localparam logic [23:0] DIV_LAST [NUM_CH] = '{
    24'(DIV0 - 1), 24'(DIV1 - 1), 24'(DIV2 - 1),
    24'(DIV3 - 1), 24'(DIV4 - 1), 24'(DIV5 - 1)
  };

  logic [15:0]       lock_cnt;
  logic              locked;
  logic [23:0]       div_cnt [NUM_CH];
  logic [NUM_CH-1:0] blink;

  // Lock sequencer: counts edges until the terminal count, then latches
  // locked and stops counting until the next reset.
  always_ff @(posedge clk) begin
    if (RST) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (!locked) begin
      lock_cnt <= lock_cnt + 16'd1;
      if (lock_cnt == LOCK_LAST) begin
        locked <= 1'b1;
      end
    end
  end

  // Channel dividers: held at zero while unlocked so that every channel
  // starts counting from the same edge that follows lock.
  always_ff @(posedge clk) begin
    if (RST || !locked) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_cnt[i] <= '0;
      end
      blink <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (div_cnt[i] == DIV_LAST[i]) begin
          div_cnt[i] <= '0;
          blink[i]   <= ~blink[i];
        end else begin
          div_cnt[i] <= div_cnt[i] + 24'd1;
        end
      end
    end
  end

  // Both fields come straight from flip-flops; no logic sits on this path.
  assign led = {locked, blink};

endmodule

// File: tb/tb_pll_led.sv
// tb_pll_led
// Directed testbench for pll_led. Instance dut_a uses default parameters,
// instance dut_b uses LOCK_CYCLES=1 and small dividers (1..6). Both share the
// clock and reset. Expected LED values come from closed-form timing:
// k edges after the lock edge, led[i] = (k / DIVi) mod 2.
module tb_pll_led;

  logic       clk;
  logic       RST;
  logic [6:0] led_a;
  logic [6:0] led_b;

  int checks = 0;
  int errors = 0;

  int div_a [6] = '{10, 20, 40, 80, 160, 320};
  int div_b [6] = '{1, 2, 3, 4, 5, 6};

  pll_led dut_a (
    .clk (clk),
    .RST (RST),
    .led (led_a)
  );

  pll_led #(
    .LOCK_CYCLES (1),
    .DIV0 (1), .DIV1 (2), .DIV2 (3),
    .DIV3 (4), .DIV4 (5), .DIV5 (6)
  ) dut_b (
    .clk (clk),
    .RST (RST),
    .led (led_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    checks++;
    if (led_a !== 7'b0000000) begin
      errors++;
      $display("[TB] FAIL reset_a: led=%b required=%b", led_a, 7'b0000000);
    end
    checks++;
    if (led_b !== 7'b0000000) begin
      errors++;
      $display("[TB] FAIL reset_b: led=%b required=%b", led_b, 7'b0000000);
    end
    RST = 1'b0;
  endtask

  // Expects RST already low; next edge is the first one with RST=0.
  task automatic test_lock(input string tag);
    for (int e = 1; e <= 63; e++) begin
      tick();
      checks++;
      if (led_a !== 7'b0000000) begin
        errors++;
        $display("[TB] FAIL %s_prelock edge %0d: led=%b required=%b",
                 tag, e, led_a, 7'b0000000);
      end
    end
    tick();
    checks++;
    if (led_a !== 7'b1000000) begin
      errors++;
      $display("[TB] FAIL %s_lock_edge64: led=%b required=%b",
               tag, led_a, 7'b1000000);
    end
  endtask

  // Runs n edges after the lock edge checking all channels against the
  // closed-form model, and verifies toggle counts at the end.
  task automatic test_channels(input string tag, input int n);
    logic [5:0] exp;
    logic [5:0] prev;
    int         tog [6];
    prev = 6'b0;
    for (int i = 0; i < 6; i++) tog[i] = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      for (int i = 0; i < 6; i++) exp[i] = ((k / div_a[i]) % 2) == 1;
      checks++;
      if (led_a !== {1'b1, exp}) begin
        errors++;
        $display("[TB] FAIL %s_chan k=%0d: led=%b required=%b",
                 tag, k, led_a, {1'b1, exp});
      end
      for (int i = 0; i < 6; i++) if (led_a[i] !== prev[i]) tog[i]++;
      prev = led_a[5:0];
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (tog[i] != n / div_a[i]) begin
        errors++;
        $display("[TB] FAIL %s_toggles ch%0d: count=%0d required=%0d",
                 tag, i, tog[i], n / div_a[i]);
      end
    end
  endtask

  // 1295 edges: led0 toggles 129 times, led5 rises at 320 and 960.
  task automatic test_run();
    test_channels("run1", 1295);
  endtask

  task automatic test_mid_reset();
    checks++;
    if (led_a[5:0] === 6'b0) begin
      errors++;
      $display("[TB] FAIL mid_precondition: led=%b required nonzero low bits",
               led_a);
    end
    RST = 1'b1;
    tick();
    checks++;
    if (led_a !== 7'b0000000) begin
      errors++;
      $display("[TB] FAIL mid_reset: led=%b required=%b", led_a, 7'b0000000);
    end
    RST = 1'b0;
    test_lock("relock");
    test_channels("run2", 660);
  endtask

  task automatic test_fast();
    logic [5:0] exp;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    checks++;
    if (led_b !== 7'b1000000) begin
      errors++;
      $display("[TB] FAIL fast_lock: led=%b required=%b", led_b, 7'b1000000);
    end
    for (int k = 1; k <= 30; k++) begin
      tick();
      for (int i = 0; i < 6; i++) exp[i] = ((k / div_b[i]) % 2) == 1;
      checks++;
      if (led_b !== {1'b1, exp}) begin
        errors++;
        $display("[TB] FAIL fast_chan k=%0d: led=%b required=%b",
                 k, led_b, {1'b1, exp});
      end
    end
  endtask

  // Reset lands on the edge where the lock counter reaches LOCK_CYCLES-1.
  task automatic test_reset_on_lock_edge();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int e = 1; e <= 63; e++) tick();
    RST = 1'b1;
    tick();
    checks++;
    if (led_a !== 7'b0000000) begin
      errors++;
      $display("[TB] FAIL lockedge_reset: led=%b required=%b",
               led_a, 7'b0000000);
    end
    RST = 1'b0;
    test_lock("lockedge");
    test_channels("run3", 40);
  endtask

  initial begin
    RST = 1'b1;
    tick();
    test_reset();
    test_lock("first");
    test_run();
    test_mid_reset();
    test_fast();
    test_reset_on_lock_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
